// File: rtl/exec_pkg.sv
// Shared encodings for exec_stage: ALU opcodes, B shift modes, status bit
// positions and FSM states. The multiply path exists only when the macro
// EXEC_STAGE_MUL_EN is defined; the encodings live here unconditionally.
package exec_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_NOT = 3'b011,
    ALU_MUL = 3'b100
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } shift_e;

  localparam int ST_Z = 0;
  localparam int ST_N = 1;
  localparam int ST_V = 2;

  // Result flags reported for an illegal opcode: only V set.
  localparam logic [2:0] STATUS_ILLEGAL = 3'b100;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MULT = 1'b1
  } exec_state_e;

endpackage

// File: rtl/exec_stage_if.sv
// Request/response bundle between a controller and exec_stage.
// The master drives operation requests; the slave (exec_stage) returns
// busy/done and the registered result and flags.
interface exec_stage_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             asel;
  logic             bsel;
  logic             loadc;
  logic             loads;
  logic [1:0]       shift;
  logic [2:0]       ALUop;
  logic [WIDTH-1:0] datapath_in;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] C;
  logic [2:0]       status;

  modport master (
    output start, asel, bsel, loadc, loads, shift, ALUop, datapath_in, A, B,
    input  busy, done, C, status
  );

  modport slave (
    input  start, asel, bsel, loadc, loads, shift, ALUop, datapath_in, A, B,
    output busy, done, C, status
  );
endinterface

// File: rtl/seq_multiplier.sv
// Unsigned shift-add multiplier. A start loads the operands; each following
// edge performs one step, WIDTH steps in total. On the cycle whose edge
// performs the final step, done is high and product shows the value being
// written by that edge, so the caller can register it on the same edge.
module seq_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               done
);

  localparam int              CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               active_q, active_d;

  // One shift-add step per cycle while active; a start reloads everything.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    done     = 1'b0;
    if (start) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        active_d = 1'b0;
        done     = 1'b1;
      end
    end
  end

  assign product = acc_d;

  // Only the activity flag needs a reset; the datapath is reloaded on start.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
    end else begin
      active_q <= active_d;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    acc_q    <= acc_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    cnt_q    <= cnt_d;
  end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: operand muxes, B shifter, single-cycle ALU, registered
// result C and flags {V,N,Z}. With EXEC_STAGE_MUL_EN defined, ALUop 100 runs
// a WIDTH-step shift-add multiply under an IDLE/MULT FSM; otherwise it is
// treated as an illegal opcode and busy stays low.
module exec_stage
  import exec_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IMM_W = 5
) (
  input logic         clk,
  input logic         reset,
  exec_stage_if.slave bus
);

  logic [WIDTH-1:0] b_shifted;
  logic [WIDTH-1:0] ain;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] alu_res;
  logic             alu_v;
  logic             alu_legal;
  logic             busy_w;
  logic             accept;
  logic             single_go;

  logic [WIDTH-1:0] c_q, c_d;
  logic [2:0]       status_q, status_d;
  logic             done_q, done_d;

  function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                   input logic signed [WIDTH-1:0] b,
                                   input logic signed [WIDTH-1:0] r);
    return (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
  endfunction

  function automatic logic sub_ovf(input logic signed [WIDTH-1:0] a,
                                   input logic signed [WIDTH-1:0] b,
                                   input logic signed [WIDTH-1:0] r);
    return (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
  endfunction

  function automatic logic [2:0] pack_status(input logic v,
                                             input logic [WIDTH-1:0] r);
    logic [2:0] s;
    s       = '0;
    s[ST_V] = v;
    s[ST_N] = r[WIDTH-1];
    s[ST_Z] = (r == '0);
    return s;
  endfunction

`ifdef EXEC_STAGE_MUL_EN
  exec_state_e        state_q, state_d;
  logic               loadc_q, loadc_d;
  logic               loads_q, loads_d;
  logic               alu_is_mul;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  assign busy_w    = (state_q == S_MULT);
  assign accept    = bus.start & ~busy_w;
  assign single_go = accept & ~alu_is_mul;
  assign mul_start = accept & alu_is_mul;

  seq_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (reset),
    .start   (mul_start),
    .a       (ain),
    .b       (bin),
    .product (mul_prod),
    .done    (mul_done)
  );
`else
  assign busy_w    = 1'b0;
  assign accept    = bus.start;
  assign single_go = accept;
`endif

  // B shifter.
  always_comb begin
    b_shifted = bus.B;
    case (bus.shift)
      SH_LSL:  b_shifted = {bus.B[WIDTH-2:0], 1'b0};
      SH_LSR:  b_shifted = {1'b0, bus.B[WIDTH-1:1]};
      SH_ASR:  b_shifted = {bus.B[WIDTH-1], bus.B[WIDTH-1:1]};
      default: b_shifted = bus.B;
    endcase
  end

  // Operand selection: A or zero; zero-extended immediate or shifted B.
  always_comb begin
    ain = bus.asel ? bus.A : '0;
    bin = bus.bsel ? WIDTH'(bus.datapath_in[IMM_W-1:0]) : b_shifted;
  end

  // Single-cycle ALU and overflow flag; also flags the multiply request.
  always_comb begin
    logic signed [WIDTH-1:0] ain_s;
    logic signed [WIDTH-1:0] bin_s;
    logic signed [WIDTH-1:0] sum_s;
    logic signed [WIDTH-1:0] dif_s;
    ain_s     = ain;
    bin_s     = bin;
    sum_s     = ain_s + bin_s;
    dif_s     = ain_s - bin_s;
    alu_res   = '0;
    alu_v     = 1'b0;
    alu_legal = 1'b1;
`ifdef EXEC_STAGE_MUL_EN
    alu_is_mul = 1'b0;
`endif
    case (bus.ALUop)
      ALU_ADD: begin
        alu_res = sum_s;
        alu_v   = add_ovf(ain_s, bin_s, sum_s);
      end
      ALU_SUB: begin
        alu_res = dif_s;
        alu_v   = sub_ovf(ain_s, bin_s, dif_s);
      end
      ALU_AND: alu_res = ain & bin;
      ALU_NOT: alu_res = ~bin;
`ifdef EXEC_STAGE_MUL_EN
      ALU_MUL: alu_is_mul = 1'b1;
`endif
      default: alu_legal = 1'b0;
    endcase
  end

  // Next-state and completion logic: single-cycle ops finish on the accept
  // edge; a multiply finishes on the edge of its last step.
  always_comb begin
    c_d      = c_q;
    status_d = status_q;
    done_d   = 1'b0;
`ifdef EXEC_STAGE_MUL_EN
    state_d = state_q;
    loadc_d = loadc_q;
    loads_d = loads_q;
`endif
    if (single_go) begin
      done_d = 1'b1;
      if (alu_legal) begin
        if (bus.loadc) c_d = alu_res;
        if (bus.loads) status_d = pack_status(alu_v, alu_res);
      end else if (bus.loads) begin
        status_d = STATUS_ILLEGAL;
      end
    end
`ifdef EXEC_STAGE_MUL_EN
    case (state_q)
      S_IDLE: begin
        if (mul_start) begin
          state_d = S_MULT;
          loadc_d = bus.loadc;
          loads_d = bus.loads;
        end
      end
      S_MULT: begin
        if (mul_done) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          if (loadc_q) c_d = mul_prod[WIDTH-1:0];
          if (loads_q) status_d = pack_status(|mul_prod[2*WIDTH-1:WIDTH],
                                              mul_prod[WIDTH-1:0]);
        end
      end
      default: state_d = S_IDLE;
    endcase
`endif
  end

  // Architectural state; reset aborts any multiply and clears the outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      done_q   <= 1'b0;
      c_q      <= '0;
      status_q <= '0;
`ifdef EXEC_STAGE_MUL_EN
      state_q  <= S_IDLE;
`endif
    end else begin
      done_q   <= done_d;
      c_q      <= c_d;
      status_q <= status_d;
`ifdef EXEC_STAGE_MUL_EN
      state_q  <= state_d;
`endif
    end
  end

`ifdef EXEC_STAGE_MUL_EN
  // Write enables captured at multiply accept; only read while in MULT.
  always_ff @(posedge clk) begin
    loadc_q <= loadc_d;
    loads_q <= loads_d;
  end
`endif

  assign bus.busy   = busy_w;
  assign bus.done   = done_q;
  assign bus.C      = c_q;
  assign bus.status = status_q;

endmodule

// File: doc/exec_stage.md
EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 Parameter WIDTH, default 16, datapath width in bits (legal 4..32).
REQ-002 Parameter IMM_W, default 5, immediate field width taken from datapath_in (legal 1..WIDTH).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 start  input  1  operation request; accepted only while busy=0.
REQ-006 asel, bsel, loadc, loads  input  1 each  operand selects and write enables, sampled on the accept edge.
REQ-007 shift  input  2  B shift mode: 00 none, 01 left 1, 10 logical right 1, 11 arithmetic right 1.
REQ-008 ALUop  input  3  000 ADD, 001 SUB, 010 AND, 011 NOT (~Bin), 100 MUL; 101-111 illegal.
REQ-009 datapath_in, A, B  input  WIDTH each  operands; sampled on the accept edge.
REQ-010 busy  output  1  high while a multi-cycle operation is in progress.
REQ-011 done  output  1  one-cycle pulse marking completion of an accepted operation.
REQ-012 C  output  WIDTH  registered result.
REQ-013 status  output  3  registered flags {V,N,Z}: status[0]=Z, status[1]=N, status[2]=V.

Function
REQ-014 Ain SHALL be A when asel=1, else all zeros.
REQ-015 Bin SHALL be {zeros, datapath_in[IMM_W-1:0]} when bsel=1, else B after the shift mode.
REQ-016 ADD/SUB/AND/NOT SHALL complete in one cycle: with start accepted at edge n, C/status update at edge n and done=1 in cycle n+1.
REQ-017 Arithmetic is modulo 2^WIDTH; C is the low WIDTH bits.
REQ-018 Z=1 iff result==0; N=result[WIDTH-1].
REQ-019 V SHALL be signed two's-complement overflow for ADD/SUB, 0 for AND/NOT, and 1 for MUL iff the upper WIDTH bits of the unsigned 2*WIDTH product are nonzero.
REQ-020 FSM states IDLE and MULT; IDLE->MULT on accepted MUL; MULT->IDLE after WIDTH shift-add steps.
REQ-021 MUL accepted at edge n: busy=1 cycles n+1..n+WIDTH; steps at edges n+1..n+WIDTH; C/status update at edge n+WIDTH; done=1 and busy=0 in cycle n+WIDTH+1.
REQ-022 start while busy=1 SHALL be ignored without side effects.
REQ-023 C SHALL update at completion only if the captured loadc=1; status only if the captured loads=1; done pulses regardless.
REQ-024 Illegal ALUop SHALL complete in one cycle with C unchanged and, if loads captured, status=3'b100.
REQ-025 Operands and controls SHALL be captured at accept; input changes during MULT SHALL not affect the result.
REQ-026 start may be accepted in the same cycle done=1 (back-to-back, no bubble).

Reset
REQ-027 reset=1 SHALL force state IDLE, busy=0, done=0, C=0, status=0 at the next edge, aborting any MUL; reset takes priority over start.

Configuration
REQ-028 Macro EXEC_STAGE_MUL_EN defined: MUL implemented per REQ-019..021.
REQ-029 Macro EXEC_STAGE_MUL_EN undefined: no MULT state or multiplier logic; ALUop 100 treated as illegal per REQ-024; busy tied 0.

Structure
REQ-030 Package exec_pkg SHALL hold ALUop and shift encodings as named constants/enums and status bit indices.
REQ-031 Sub-module seq_multiplier (WIDTH parameter; start/operands in, 2*WIDTH product and done out) SHALL implement the shift-add iteration; exec_stage holds the FSM, operand muxes, and C/status registers.

Verification (WIDTH=16, IMM_W=5)
REQ-032 A=0x7FFF, B=0x0001, asel=1, bsel=0, shift=00, ADD, loadc=loads=1 -> next cycle done=1, C=0x8000, status=3'b110.
REQ-033 A=0x0005, datapath_in=0xFFE5, bsel=1, SUB, loads=1 -> C=0x0000 (5-5), status=3'b001.
REQ-034 A=0x0003, B=0x0004, MUL, loadc=loads=1 -> busy 16 cycles, done in cycle 17 after accept, C=0x000C, status=3'b000; start pulsed mid-op ignored.
REQ-035 A=0x0100, B=0x0100, MUL -> C=0x0000, status=3'b101; reset asserted at step 8 of a second MUL -> next cycle busy=0, done=0, C=0, status=0.
REQ-036 B=0x8001, shift=11, asel=0, ADD, loadc=0, loads=1 -> C unchanged, status=3'b010 (result 0xC000); ALUop=111 with loads=1 -> status=3'b100, C unchanged.
